// File: rtl/dsp_pkg.sv
// dsp_pkg: shared command width, status byte layout and issue FSM encoding
package dsp_pkg;
  localparam int CMD_W        = 8;
  localparam int STAT_OVF     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;
  localparam int STAT_CNT_MSB = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} issue_state_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port RAM with registered read (read-before-write on same address)
module sync_fifo_mem #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (!reset_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: buffers SPI command bytes and replays them to the DSP engine one pulse at a time,
// with a rate-limiting gap between pulses and a registered status byte for MISO.
module spi_cmd_fifo
  import dsp_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = CMD_W,
  parameter int ISSUE_GAP  = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_byte,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic                  engine_ready,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            status_byte
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = CNT_W > 5 ? CNT_W : 5;
  issue_state_t state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [AW-1:0] wptr, rptr;
  logic [CNT_W-1:0] count_d;
  logic [CW-1:0] count_ext;
  logic push, pop, ovf_set;
  // a pop in the same cycle frees a slot, so a push against a full buffer still lands
  assign push      = in_valid && !flush && (!full || pop);
  assign ovf_set   = in_valid && !flush && full && !pop;
  assign count_d   = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign count_ext = CW'(count);
  assign out_valid = state_q == ISSUE;
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (engine_ready && !empty && !flush) begin
                 pop     = 1'b1;
                 state_d = ISSUE;
               end
      ISSUE:   begin
                 gap_d   = 4'(ISSUE_GAP - 1);
                 state_d = ISSUE_GAP > 1 ? GAP : IDLE;
               end
      GAP:     begin
                 gap_d   = gap_q - 4'd1;
                 state_d = gap_q == 4'd1 ? IDLE : GAP;
               end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
      status_byte <= 8'(1 << STAT_EMPTY);
    end else begin
      wptr                        <= flush ? '0 : wptr + AW'(push);
      rptr                        <= flush ? '0 : rptr + AW'(pop);
      count                       <= count_d;
      empty                       <= count_d == '0;
      full                        <= count_d == CNT_W'(DEPTH);
      overflow                    <= !flush && (overflow || ovf_set);
      status_byte[STAT_OVF]       <= overflow;
      status_byte[STAT_FULL]      <= full;
      status_byte[STAT_EMPTY]     <= empty;
      status_byte[STAT_CNT_MSB:0] <= count_ext > CW'(31) ? 5'd31 : count_ext[4:0];
    end
  end
  sync_fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push),
    .waddr   (wptr),
    .wdata   (in_byte),
    .re      (pop),
    .raddr   (rptr),
    .rdata   (out_byte)
  );
endmodule

// File: tb/tb_spi_cmd_fifo.sv
// tb_spi_cmd_fifo: scoreboard bench; stimulus pushes expected bytes into a queue,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_spi_cmd_fifo;
  localparam int DEPTH = 32;
  localparam int GAPC  = 2;
  logic clk = 0, reset_n = 0, in_valid = 0, flush = 0, engine_ready = 0;
  logic [7:0] in_byte = 0;
  logic [7:0] out_byte, status_byte;
  logic out_valid, empty, full, overflow;
  logic [5:0] count;
  int n_checks = 0, n_fail = 0, cyc = 0, n_ov = 0, last_ov = -1;
  int pc, nb, mx, t;
  bit model_ovf = 0;
  logic [7:0] exp_q[$];
  int gaps[$];

  spi_cmd_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8), .ISSUE_GAP(GAPC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .flush        (flush),
    .engine_ready (engine_ready),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .status_byte  (status_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic eq(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      n_ov++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got byte 0x%0h with nothing expected", out_byte);
      end else eq("out_byte", out_byte, exp_q.pop_front());
      if (last_ov >= 0) begin
        gaps.push_back(cyc - last_ov);
        n_checks++;
        if (cyc - last_ov < GAPC + 1) begin
          n_fail++;
          $display("FAIL issue_spacing: got %0d cycles expected >= %0d", cyc - last_ov, GAPC + 1);
        end
      end
      last_ov = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] b);
    in_valid = 1;
    in_byte  = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else model_ovf = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    engine_ready = 1;
    while (exp_q.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    eq("drain_done", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    eq("rst_count", count, 0);
    eq("rst_empty", empty, 1);
    eq("rst_full", full, 0);
    eq("rst_overflow", overflow, 0);
    eq("rst_out_valid", out_valid, 0);
    eq("rst_out_byte", out_byte, 0);
    eq("rst_status", status_byte, 8'h20);
    reset_n = 1;
    engine_ready = 1;
    pc = cyc;
    push(8'hA5);
    drain();
    eq("latency", last_ov - pc, 2);
    eq("pass_count", count, 0);
    eq("pass_status", status_byte, 8'h20);

    engine_ready = 0;
    nb = n_ov;
    for (int i = 1; i <= 5; i++) push(8'(i));
    tick();
    tick();
    eq("busy_count", count, 5);
    eq("busy_status", status_byte, 8'h05);
    eq("busy_no_issue", n_ov, nb);
    gaps.delete();
    drain();
    eq("busy_pulses", gaps.size(), 5);
    for (int i = 1; i < gaps.size(); i++) eq("busy_spacing", gaps[i], GAPC + 1);

    mx = 0;
    for (int i = 0; i < 100; i++) begin
      push(8'(i));
      if (int'(count) > mx) mx = int'(count);
      repeat (2) begin
        tick();
        if (int'(count) > mx) mx = int'(count);
      end
    end
    drain();
    eq("wrap_max_count", mx, 1);
    eq("wrap_count", count, 0);

    engine_ready = 0;
    nb = n_ov;
    for (int i = 0; i < 33; i++) push(8'(8'h40 + i));
    tick();
    tick();
    eq("ovf_full", full, 1);
    eq("ovf_flag", overflow, model_ovf);
    eq("ovf_count", count, 32);
    eq("ovf_status", status_byte, 8'hDF);
    drain();
    eq("ovf_pulses", n_ov - nb, 32);
    eq("ovf_sticky", overflow, model_ovf);
    eq("ovf_drained_status", status_byte, 8'hA0);
    flush = 1;
    tick();
    flush = 0;
    model_ovf = 0;
    tick();
    eq("flush_clears_ovf", overflow, model_ovf);
    eq("flush_status", status_byte, 8'h20);

    engine_ready = 0;
    for (int i = 0; i < 32; i++) push(8'(8'h80 + i));
    tick();
    in_valid = 1;
    in_byte = 8'h99;
    engine_ready = 1;
    exp_q.push_back(8'h99);
    tick();
    in_valid = 0;
    eq("pwf_overflow", overflow, 0);
    eq("pwf_count", count, 32);
    drain();
    eq("pwf_overflow_after", overflow, 0);

    engine_ready = 0;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    engine_ready = 1;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    eq("flush_issue_seen", out_valid, 1);
    nb = n_ov;
    flush = 1;
    in_valid = 1;
    in_byte = 8'hEE;
    tick();
    flush = 0;
    in_valid = 0;
    exp_q.delete();
    eq("flush_issue_fired", n_ov, nb + 1);
    eq("flush_count", count, 0);
    eq("flush_empty", empty, 1);
    repeat (10) tick();
    eq("flush_no_more", n_ov, nb + 1);
    eq("flush_dropped", count, 0);
    eq("flush_ovf", overflow, 0);

    engine_ready = 0;
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    engine_ready = 1;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    eq("mid_rst_issue_seen", out_valid, 1);
    tick();
    reset_n = 0;
    exp_q.delete();
    model_ovf = 0;
    tick();
    eq("mid_rst_out_valid", out_valid, 0);
    eq("mid_rst_count", count, 0);
    eq("mid_rst_ovf", overflow, model_ovf);
    reset_n = 1;
    nb = n_ov;
    push(8'h7E);
    drain();
    eq("post_rst_issue", n_ov, nb + 1);

    for (int i = 0; i < 600; i++) begin
      engine_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH - 2) push(8'($urandom));
      else tick();
    end
    drain();
    eq("rand_count", count, 0);
    eq("rand_empty", empty, 1);
    eq("rand_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
